// File: rtl/soc_fetch_pkg.sv
// rtl/soc_fetch_pkg.sv - shared types and constants for the instruction fetch unit
package soc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ABORT = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/wb_ifetch_if.sv
// rtl/wb_ifetch_if.sv - Wishbone classic read bus between fetch unit and instruction memory
interface wb_ifetch_if;
  logic        cyc_o;
  logic        stb_o;
  logic [29:0] adr_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  modport master (
    output cyc_o, stb_o, adr_o, we_o, sel_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, adr_o, we_o, sel_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - instruction/PC buffer between the bus side and the consumer
module ifetch_fifo
  import soc_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so reset and flush present a clean output.
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Entry storage, written at the tail
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/wb_ifetch.sv
// rtl/wb_ifetch.sv - Wishbone instruction prefetcher; WB_IFETCH_TIMEOUT_EN adds a request timeout
module wb_ifetch
  import soc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 2,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_ifetch_if.master  bus,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic         inst_valid_o,
  output logic [31:0]  inst_o,
  output logic [31:0]  inst_pc_o,
  input  logic         inst_ready_i,
  output logic         fault_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state;
  logic             req;
  logic [29:0]      adr;
  logic             fault;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic             full;
  logic             empty;
  logic             pop;
  logic             ack_push;
  logic             tmo_hit;
  fetch_entry_t     head;
  fetch_entry_t     entry;
  logic             unused_bits;

  assign unused_bits = ^{redirect_pc_i[1:0], full};

  assign pop        = !empty && inst_ready_i;
  // Slots are counted after the head leaves this cycle.
  assign free_slots = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
  // A redirect in the ack cycle discards the word; errors never push.
  assign ack_push   = (state == S_REQ) && bus.ack_i && !bus.err_i && !redirect_i;
  assign entry      = '{inst: bus.dat_i, pc: {adr, 2'b00}};

  ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (ack_push),
    .din    (entry),
    .pop    (pop),
    .flush  (redirect_i),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

`ifdef WB_IFETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (state == S_REQ) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Cycles waited in REQ since entry or the most recent ack
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt <= '0;
    end else if (state != S_REQ || bus.ack_i || redirect_i) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo_hit = 1'b0;
`endif

  // Fetch sequencer: issues requests, advances the fetch address, holds the sticky fault
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      req   <= 1'b0;
      adr   <= RESET_PC[31:2];
      fault <= 1'b0;
    end else if (redirect_i) begin
      state <= S_ABORT;
      req   <= 1'b0;
      adr   <= redirect_pc_i[31:2];
      fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (free_slots != '0) begin
            state <= S_REQ;
            req   <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.err_i) begin
            state <= S_FAULT;
            req   <= 1'b0;
            fault <= 1'b1;
          end else if (bus.ack_i) begin
            adr <= adr + 30'd1;
            if (free_slots <= CNT_W'(1)) begin
              state <= S_IDLE;
              req   <= 1'b0;
            end
          end else if (tmo_hit) begin
            state <= S_FAULT;
            req   <= 1'b0;
            fault <= 1'b1;
          end
        end
        S_ABORT: begin
          state <= S_REQ;
          req   <= 1'b1;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cyc_o = req;
  assign bus.stb_o = req;
  assign bus.adr_o = adr;
  assign bus.we_o  = 1'b0;
  assign bus.sel_o = WB_SEL_ALL;

  assign inst_valid_o = !empty;
  assign inst_o       = head.inst;
  assign inst_pc_o    = head.pc;
  assign fault_o      = fault;
endmodule

// File: tb/tb_wb_ifetch.sv
// tb/tb_wb_ifetch.sv - self-checking bench for wb_ifetch with a 1-cycle-ack memory model
module tb_wb_ifetch;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] tgt;
    logic [29:0] exp_adr;
    logic [31:0] exp_pc;
    int          n;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fault;
  logic        stall;
  logic        err_en;
  logic [29:0] err_adr;
  logic        fire;
  logic        hit_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  vec_t vecs[4];

  always #5 clk = ~clk;

  wb_ifetch_if bus();

  wb_ifetch #(
    .RESET_PC    (32'h0000_0000),
    .FIFO_DEPTH  (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .inst_valid_o  (inst_valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_ready_i  (inst_ready),
    .fault_o       (fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return (pc << 5) + 32'h13;
  endfunction

  // Memory slave: acknowledges (or errors) the cycle after a fresh strobe
  assign fire    = bus.cyc_o && bus.stb_o && !bus.ack_i && !bus.err_i && !stall;
  assign hit_err = err_en && (bus.adr_o == err_adr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack_i <= 1'b0;
      bus.err_i <= 1'b0;
      bus.dat_i <= '0;
    end else begin
      bus.ack_i <= fire && !hit_err;
      bus.err_i <= fire && hit_err;
      bus.dat_i <= mem_word({bus.adr_o, 2'b00});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard compare for a pop happening at the coming edge, then advance one cycle
  task automatic tick();
    exp_t e;
    if (inst_valid && inst_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h inst %h expected no output", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        if (inst_pc !== e.pc || inst !== e.inst) begin
          n_bad++;
          $display("FAIL pop_data: got pc %h inst %h expected pc %h inst %h", inst_pc, inst, e.pc, e.inst);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc + 32'(4 * i), inst: mem_word(pc + 32'(4 * i))});
    end
  endtask

  task automatic drain(input int budget);
    inst_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    inst_ready = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    int n_stb;
    bit found;

    vecs[0] = '{tgt: 32'h0000_0100, exp_adr: 30'h0000_0040, exp_pc: 32'h0000_0100, n: 3};
    vecs[1] = '{tgt: 32'h0000_0203, exp_adr: 30'h0000_0080, exp_pc: 32'h0000_0200, n: 2};
    vecs[2] = '{tgt: 32'hFFFF_FFF8, exp_adr: 30'h3FFF_FFFE, exp_pc: 32'hFFFF_FFF8, n: 4};
    vecs[3] = '{tgt: 32'h1234_5678, exp_adr: 30'h048D_159E, exp_pc: 32'h1234_5678, n: 2};

    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    stall = 1'b0; err_en = 1'b0; err_adr = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_cyc", 32'(bus.cyc_o), 32'd0);
    check("rst_stb", 32'(bus.stb_o), 32'd0);
    check("rst_adr", {2'b00, bus.adr_o}, 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("we_tied", 32'(bus.we_o), 32'd0);
    check("sel_tied", 32'(bus.sel_o), 32'hF);

    // First request on the first edge after release, first word two cycles later
    rst_n = 1'b1;
    tick();
    check("first_req_stb", 32'(bus.stb_o), 32'd1);
    check("first_req_adr", {2'b00, bus.adr_o}, 32'd0);
    tick();
    check("valid_at_n1", 32'(inst_valid), 32'd0);
    tick();
    check("valid_at_n2", 32'(inst_valid), 32'd1);
    check("first_inst", inst, 32'h13);
    push_exp(32'h0, 3);
    drain(40);

    // Redirect table
    for (int v = 0; v < 4; v++) begin
      do_redirect(vecs[v].tgt);
      check("abort_cyc", 32'(bus.cyc_o), 32'd0);
      tick();
      check("redir_cyc", 32'(bus.cyc_o), 32'd1);
      check("redir_adr", {2'b00, bus.adr_o}, {2'b00, vecs[v].exp_adr});
      push_exp(vecs[v].exp_pc, vecs[v].n);
      drain(40);
    end

    // Consumer stalled: two acks fill the buffer then the bus goes quiet
    do_redirect(32'h40);
    n_ack = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cyc_o && bus.ack_i) n_ack++;
      tick();
    end
    check("stall_acks", 32'(n_ack), 32'd2);
    check("stall_cyc", 32'(bus.cyc_o), 32'd0);
    check("stall_hold_pc", inst_pc, 32'h40);
    check("stall_hold_inst", inst, mem_word(32'h40));
    push_exp(32'h40, 4);
    drain(40);

    // Redirect in the ack cycle of PC 0x8 discards that word
    do_redirect(32'h0);
    push_exp(32'h0, 2);
    inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.cyc_o && bus.ack_i && bus.adr_o == 30'h2) found = 1'b1;
      else tick();
    end
    check("ack_pc8_seen", 32'(found), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check("late_redir_abort", 32'(bus.cyc_o), 32'd0);
    check("late_redir_q", 32'(exp_q.size()), 32'd0);
    tick();
    check("late_redir_cyc", 32'(bus.cyc_o), 32'd1);
    check("late_redir_adr", {2'b00, bus.adr_o}, 32'h40);
    push_exp(32'h100, 2);
    drain(40);

    // Bus error on PC 0xC with words still buffered
    err_en = 1'b1;
    err_adr = 30'h3;
    do_redirect(32'h0);
    repeat (8) tick();
    check("err_pre_full_cyc", 32'(bus.cyc_o), 32'd0);
    push_exp(32'h0, 3);
    for (int i = 0; i < 60 && !fault; i++) begin
      inst_ready = (i % 8 == 0);
      tick();
    end
    inst_ready = 1'b0;
    check("err_fault", 32'(fault), 32'd1);
    check("err_cyc", 32'(bus.cyc_o), 32'd0);
    check("err_buf_valid", 32'(inst_valid), 32'd1);
    check("err_buf_pc", inst_pc, 32'h8);
    repeat (3) tick();
    check("fault_no_req", 32'(bus.cyc_o), 32'd0);
    drain(20);
    check("fault_empty", 32'(inst_valid), 32'd0);
    check("fault_sticky", 32'(fault), 32'd1);
    err_en = 1'b0;
    do_redirect(32'h0);
    check("fault_cleared", 32'(fault), 32'd0);
    push_exp(32'h0, 2);
    drain(40);

    // Slave never acknowledges
    stall = 1'b1;
    do_redirect(32'h80);
    tick();
    n_stb = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.stb_o) n_stb++;
      tick();
    end
`ifdef WB_IFETCH_TIMEOUT_EN
    check("tmo_stb_cycles", 32'(n_stb), 32'd16);
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_cyc", 32'(bus.cyc_o), 32'd0);
`else
    check("wait_stb_cycles", 32'(n_stb), 32'd100);
    check("wait_fault", 32'(fault), 32'd0);
`endif
    stall = 1'b0;
    do_redirect(32'h0);
    check("tmo_clear_fault", 32'(fault), 32'd0);

    // Reset pulse in the middle of a transfer
    do_redirect(32'h200);
    repeat (4) tick();
    check("pre_rst_stb", 32'(bus.stb_o), 32'd1);
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc", 32'(bus.cyc_o), 32'd0);
    check("async_rst_stb", 32'(bus.stb_o), 32'd0);
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_adr", {2'b00, bus.adr_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("restart_stb", 32'(bus.stb_o), 32'd1);
    check("restart_adr", {2'b00, bus.adr_o}, 32'd0);
    push_exp(32'h0, 2);
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
